// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the inverse key schedule.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, RUN} state_e;

  // Indexed by round number; entry 0 and 11..15 are never used as Rcon.
  localparam logic [15:0][7:0] RCON = {
    40'h0,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (the InvMixColumns coefficients 9, b, d, e).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic word_t inv_mix_col(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row-major table; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] idx_n;

  assign idx_n = ~in_i;
  assign out_o = SBOX[{idx_n, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: emits round keys 10..0 on a valid/ready stream.
// Optional INV_KEY_MIXCOL_EN: rounds 1..9 are output in equivalent-inverse-cipher form.
module inv_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           done_q, done_d;

  word_t          w0, w1, w2, w3;
  word_t          p0, p1, p2, p3;
  logic [3:0][7:0] rot_b, sub_b;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot_b = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_b[g]),
      .out_o (sub_b[g])
    );
  end

  assign p0 = w0 ^ sub_b ^ {RCON[rnd_q], 24'h0};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          rnd_d   = 4'(AES_NR);
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = {p0, p1, p2, p3};
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign rk_round = rnd_q;
  assign done     = done_q;

`ifdef INV_KEY_MIXCOL_EN
  // key_q stays raw so the schedule recurrence is unaffected.
  always_comb begin
    rk_out = key_q;
    if (rnd_q != 4'd0 && rnd_q != 4'(AES_NR)) rk_out = inv_mix_columns(key_q);
  end
`else
  assign rk_out = key_q;
`endif

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion; reference S-box is derived from GF(2^8) inversion.
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic         busy, rk_valid, done;
  logic [127:0] last_key, rk_out;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  inv_key_expansion dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .last_key (last_key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] APPA_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] APPA_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] APPA_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb [256];
  logic       m_run = 1'b0;
  logic       m_done = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = xt(a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < i; k++) r = xt(r);
    return r;
  endfunction

  function automatic logic [127:0] prev_key(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3, p3, s;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    p3 = w3 ^ w2;
    s  = {sb[p3[23:16]], sb[p3[15:8]], sb[p3[7:0]], sb[p3[31:24]]};
    return {w0 ^ s ^ {rcon(i), 24'h0}, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] shown(input exp_t e);
`ifdef INV_KEY_MIXCOL_EN
    if (e.rnd != 4'd0 && e.rnd != 4'd10)
      return {imc_col(e.key[127:96]), imc_col(e.key[95:64]),
              imc_col(e.key[63:32]), imc_col(e.key[31:0])};
`endif
    return e.key;
  endfunction

  task automatic gen_seq(input logic [127:0] k);
    exp_t e;
    logic [127:0] ek;
    ek = k;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = ek;
      if (k == APPA_K10 && r == 9) e.key = APPA_K9;
      if (k == APPA_K10 && r == 0) e.key = APPA_K0;
      exp_q.push_back(e);
      if (r > 0) ek = prev_key(ek, r);
    end
  endtask

  // Called #1 after a rising edge: checks the current cycle, then advances one clock.
  task automatic run_cycle(input logic rdy);
    exp_t e;
    logic n_run, n_done;
    rk_ready = rdy;
    check("busy", busy, m_run);
    check("rk_valid", rk_valid, m_run);
    check("done", done, m_done);
    n_run  = m_run;
    n_done = 1'b0;
    if (m_run) begin
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("rk_round", rk_round, e.rnd);
        check("rk_out", rk_out, shown(e));
        if (rdy) begin
          void'(exp_q.pop_front());
          if (e.rnd == 4'd0) begin
            n_run  = 1'b0;
            n_done = 1'b1;
          end
        end
      end else begin
        n_run = 1'b0;
      end
    end else if (start) begin
      gen_seq(last_key);
      n_run = 1'b1;
    end
    @(posedge clk);
    #1;
    m_run  = n_run;
    m_done = n_done;
  endtask

  task automatic run_until_idle(input int maxc, input bit rand_rdy, input bit noise);
    int c;
    c = 0;
    while (m_run && c < maxc) begin
      if (noise) begin
        start    = (exp_q.size() > 1);
        last_key = {$urandom, $urandom, $urandom, $urandom};
      end
      run_cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      c++;
    end
    start = 1'b0;
    check("seq_finished", m_run, 1'b0);
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    run_cycle(1'b1);
    run_cycle(1'b1);
  endtask

  task automatic launch(input logic [127:0] k);
    start    = 1'b1;
    last_key = k;
    run_cycle(1'b1);
    start    = 1'b0;
  endtask

  initial begin
    int c;
    rst      = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    init_sbox();
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", rk_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rk_out", rk_out, 128'h0);
    check("rst_rk_round", rk_round, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(1'b1);

    // Appendix A key, consumer always ready
    launch(APPA_K10);
    run_until_idle(40, 1'b0, 1'b0);

    // random backpressure
    launch(APPA_K10);
    run_until_idle(200, 1'b1, 1'b0);

    // start with another key while running must be ignored
    launch(APPA_K10);
    run_until_idle(200, 1'b1, 1'b1);

    // asynchronous reset while round 5 is on the output
    launch({$urandom, $urandom, $urandom, $urandom});
    c = 0;
    while (m_run && exp_q.size() != 0 && exp_q[0].rnd != 4'd5 && c < 100) begin
      run_cycle(1'($urandom_range(0, 1)));
      c++;
    end
    check("reached_round5", rk_round, 4'd5);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", rk_valid, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_rk_out", rk_out, 128'h0);
    check("arst_rk_round", rk_round, 4'd0);
    exp_q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(1'b1);
    run_cycle(1'b1);
    launch(APPA_K10);
    run_until_idle(40, 1'b0, 1'b0);

    // start held across two sequences: App. A key then all-zero key
    start    = 1'b1;
    last_key = APPA_K10;
    run_cycle(1'b1);
    last_key = '0;
    c = 0;
    while (!m_done && c < 40) begin
      run_cycle(1'b1);
      c++;
    end
    check("b2b_first_done", m_done, 1'b1);
    run_cycle(1'b1);
    start = 1'b0;
    run_until_idle(40, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
